baser_257b_lane_scheduler: RTL

Round-robin scheduler that shares one 257b transcoded lane between N_REQ block sources (pattern generators or transcoder instances) using valid/ready handshakes. It grants a source for a bounded burst of blocks and inserts a fixed idle 257b block whenever no source supplies one, so the lane never starves. The output is registered and drives the 257b checker and downstream lane logic directly. It also exports per-lane statistics.

---
 rtl/baser_257b_pkg.sv | 26 ++
 rtl/baser_rr_picker.sv | 38 +++
 rtl/baser_257b_lane_scheduler.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/baser_257b_pkg.sv
// Shared constants, scheduler state encoding and idle-block builder for the
// 257b lane scheduler.
package baser_257b_pkg;

    localparam int TC_WIDTH = 257;

    typedef enum logic [1:0] {
        ST_DISABLED = 2'd0,
        ST_ARB      = 2'd1,
        ST_BURST    = 2'd2
    } sched_state_t;

    // Index width for a given requester count, never narrower than one bit.
    function automatic int grant_width(input int n_req);
        return (n_req > 1) ? $clog2(n_req) : 1;
    endfunction

    // Control-header idle block: header 0, 4-bit type 0, fill byte repeated
    // upward from bit 5 and cut at the top of the block.
    function automatic logic [TC_WIDTH-1:0] idle_257b(input logic [7:0] fill);
        logic [255:0] rep;
        rep = {32{fill}};
        return {rep[TC_WIDTH-6:0], 5'b00000};
    endfunction

endpackage

// File: rtl/baser_rr_picker.sv
// Combinational round-robin picker: first valid requester at or after ptr,
// wrapping modulo N_REQ.
module baser_rr_picker
    import baser_257b_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int GRANT_W = grant_width(N_REQ)
) (
    input  logic [N_REQ-1:0]   valid,
    input  logic [GRANT_W-1:0] ptr,
    output logic [N_REQ-1:0]   grant_oh,
    output logic [GRANT_W-1:0] grant_idx,
    output logic               any_valid
);

    logic [GRANT_W-1:0] cand_idx;

    // Scan farthest-first so the candidate closest to ptr is the last to win.
    always_comb begin
        grant_idx = '0;
        any_valid = 1'b0;
        cand_idx  = '0;
        for (int j = N_REQ - 1; j >= 0; j--) begin
            cand_idx = GRANT_W'((int'(ptr) + j) % N_REQ);
            if (valid[cand_idx]) begin
                grant_idx = cand_idx;
                any_valid = 1'b1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_onehot
            assign grant_oh[gi] = any_valid && (grant_idx == GRANT_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/baser_257b_lane_scheduler.sv
// Round-robin burst scheduler sharing one registered 257b lane between N_REQ
// block sources, filling empty slots with an idle block.
module baser_257b_lane_scheduler #(
    parameter int         N_REQ     = 4,
    parameter int         TC_WIDTH  = baser_257b_pkg::TC_WIDTH,
    parameter logic [7:0] IDLE_FILL = 8'h55
) (
    input  logic                      clk,
    input  logic                      i_rst,
    input  logic                      i_enable,
    input  logic [7:0]                i_burst_len,
    input  logic [N_REQ-1:0]          i_req_valid,
    input  logic [N_REQ*TC_WIDTH-1:0] i_req_data,
    output logic [N_REQ-1:0]          o_req_ready,
    output logic [TC_WIDTH-1:0]       o_tx_coded,
    output logic                      o_tx_valid,
    input  logic                      i_tx_ready,
    output logic [2:0]                o_grant_idx,
    output logic [31:0]               o_blk_count,
    output logic [31:0]               o_idle_count
);
    import baser_257b_pkg::*;

    localparam int GRANT_W = grant_width(N_REQ);
    localparam logic [TC_WIDTH-1:0] IDLE_BLK = TC_WIDTH'(idle_257b(IDLE_FILL));

    logic [TC_WIDTH-1:0] req_blk [N_REQ];

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign req_blk[gi] = i_req_data[gi*TC_WIDTH +: TC_WIDTH];
        end
    endgenerate

    sched_state_t        state_reg;
    logic [GRANT_W-1:0]  rr_ptr_reg;
    logic [GRANT_W-1:0]  grant_reg;
    logic [7:0]          burst_cnt_reg;
    logic [7:0]          burst_len_reg;
    logic [TC_WIDTH-1:0] tx_coded_reg;
    logic                tx_valid_reg;
    logic [31:0]         blk_count_reg;
    logic [31:0]         idle_count_reg;

    logic [N_REQ-1:0]    pick_oh;
    logic [GRANT_W-1:0]  pick_idx;
    logic                pick_any;
    logic                slot_free;
    logic                grantee_valid;
    logic [7:0]          eff_len;

    baser_rr_picker #(
        .N_REQ   (N_REQ),
        .GRANT_W (GRANT_W)
    ) u_picker (
        .valid     (i_req_valid),
        .ptr       (rr_ptr_reg),
        .grant_oh  (pick_oh),
        .grant_idx (pick_idx),
        .any_valid (pick_any)
    );

    function automatic logic [GRANT_W-1:0] wrap_inc(input logic [GRANT_W-1:0] idx);
        return (int'(idx) == N_REQ - 1) ? '0 : idx + GRANT_W'(1);
    endfunction

    assign slot_free     = !tx_valid_reg || i_tx_ready;
    assign grantee_valid = i_req_valid[grant_reg];
    assign eff_len       = (i_burst_len == 8'd0) ? 8'd1 : i_burst_len;

    // Ready mirrors exactly the load decisions made in the sequential block.
    always_comb begin
        o_req_ready = '0;
        if (i_enable && slot_free) begin
            case (state_reg)
                ST_ARB:   o_req_ready = pick_oh;
                ST_BURST: o_req_ready[grant_reg] = grantee_valid;
                default:  o_req_ready = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg      <= ST_DISABLED;
            rr_ptr_reg     <= '0;
            grant_reg      <= '0;
            burst_cnt_reg  <= '0;
            burst_len_reg  <= '0;
            tx_coded_reg   <= '0;
            tx_valid_reg   <= 1'b0;
            blk_count_reg  <= '0;
            idle_count_reg <= '0;
        end else begin
            if (tx_valid_reg && i_tx_ready) begin
                tx_valid_reg <= 1'b0;
            end
            case (state_reg)
                ST_DISABLED: begin
                    if (i_enable) begin
                        state_reg <= ST_ARB;
                    end
                end
                ST_ARB: begin
                    if (!i_enable) begin
                        state_reg <= ST_DISABLED;
                    end else if (slot_free) begin
                        tx_valid_reg <= 1'b1;
                        if (pick_any) begin
                            tx_coded_reg  <= req_blk[pick_idx];
                            grant_reg     <= pick_idx;
                            burst_cnt_reg <= 8'd1;
                            burst_len_reg <= eff_len;
                            blk_count_reg <= blk_count_reg + 32'd1;
                            if (eff_len > 8'd1) begin
                                state_reg <= ST_BURST;
                            end else begin
                                rr_ptr_reg <= wrap_inc(pick_idx);
                            end
                        end else begin
                            tx_coded_reg   <= IDLE_BLK;
                            idle_count_reg <= idle_count_reg + 32'd1;
                        end
                    end
                end
                ST_BURST: begin
                    if (!i_enable) begin
                        state_reg <= ST_DISABLED;
                    end else if (slot_free) begin
                        tx_valid_reg <= 1'b1;
                        if (grantee_valid) begin
                            tx_coded_reg  <= req_blk[grant_reg];
                            burst_cnt_reg <= burst_cnt_reg + 8'd1;
                            blk_count_reg <= blk_count_reg + 32'd1;
                            if (burst_cnt_reg + 8'd1 >= burst_len_reg) begin
                                state_reg  <= ST_ARB;
                                rr_ptr_reg <= wrap_inc(grant_reg);
                            end
                        end else begin
                            // Grantee ran dry: keep the lane fed and hand over.
                            tx_coded_reg   <= IDLE_BLK;
                            idle_count_reg <= idle_count_reg + 32'd1;
                            state_reg      <= ST_ARB;
                            rr_ptr_reg     <= wrap_inc(grant_reg);
                        end
                    end
                end
                default: state_reg <= ST_DISABLED;
            endcase
        end
    end

    assign o_tx_coded   = tx_coded_reg;
    assign o_tx_valid   = tx_valid_reg;
    assign o_grant_idx  = 3'(grant_reg);
    assign o_blk_count  = blk_count_reg;
    assign o_idle_count = idle_count_reg;

endmodule
